// File: rtl/fpu_pkg.sv
// Shared FP issue definitions: alu_op codes, rounding-mode encodings,
// sequencer state encoding and rounding-mode helpers.
package fpu_pkg;

  localparam logic [4:0] ALU_OP_FADD  = 5'd0;
  localparam logic [4:0] ALU_OP_FSUB  = 5'd1;
  localparam logic [4:0] ALU_OP_FMUL  = 5'd2;
  localparam logic [4:0] ALU_OP_FDIV  = 5'd3;
  localparam logic [4:0] ALU_OP_FSQRT = 5'd4;
  localparam logic [4:0] ALU_OP_FMIN  = 5'd5;
  localparam logic [4:0] ALU_OP_FMAX  = 5'd6;
  localparam logic [4:0] ALU_OP_FEQ   = 5'd7;
  localparam logic [4:0] ALU_OP_FLT   = 5'd8;
  localparam logic [4:0] ALU_OP_FLE   = 5'd9;
  localparam logic [4:0] ALU_OP_CVT   = 5'd20;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Encodings 101/110 are reserved and 111 is only meaningful as an
  // instruction field, so a resolved mode above RMM cannot be executed.
  function automatic logic is_legal_rm(input logic [2:0] rm);
    return rm <= RM_RMM;
  endfunction

  function automatic logic [2:0] resolve_rm(input logic [2:0] inst_rm,
                                            input logic [2:0] frm);
    return (inst_rm == RM_DYN) ? frm : inst_rm;
  endfunction

endpackage

// File: rtl/fpu_issue_sequencer.sv
// Single-issue sequencer for the FP ALU / float-to-int datapath: accepts an op,
// holds datapath controls for ALU_LAT cycles, captures and returns the result.
module fpu_issue_sequencer
  import fpu_pkg::*;
#(
  parameter int         ALU_LAT = 2,
  parameter logic [4:0] CVT_OP  = ALU_OP_CVT,
  parameter logic [2:0] FRM_RST = RM_RNE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [2:0]  req_rm,
  input  logic        req_unsigned,
  input  logic        frm_we,
  input  logic [2:0]  frm_wdata,
  output logic [2:0]  frm,
  output logic [31:0] dp_read_data1,
  output logic [31:0] dp_read_data2,
  output logic [4:0]  dp_alu_op,
  output logic [2:0]  dp_rm,
  output logic        dp_cvt_en,
  output logic        dp_is_unsigned,
  output logic [31:0] dp_fp_rs1,
  input  logic [31:0] dp_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_illegal
);

  localparam int               CNT_W    = $clog2(ALU_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       rm_resolved;
  logic             rm_legal;
  logic             accept;
  logic             exec_last;

  // frm is sampled before any same-edge CSR write lands, so an op accepted
  // alongside a frm write still sees the old mode.
  assign rm_resolved = resolve_rm(req_rm, frm);
  assign rm_legal    = is_legal_rm(rm_resolved);
  assign accept      = req_valid && req_ready;
  assign exec_last   = (state == EXEC) && (cnt == CNT_LAST);

  // NOTE: every register here uses non-blocking assignment so all state
  // updates on an edge see the same pre-edge values, independent of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept)    state_next = rm_legal ? EXEC : DONE;
      EXEC:    if (exec_last) state_next = DONE;
      DONE:    if (rsp_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Accepting only in IDLE keeps the response from the previous op intact
  // until it has been consumed.
  always_comb begin
    req_ready = (state == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == EXEC) begin
      cnt <= exec_last ? '0 : cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  // Datapath controls load only for legal ops and otherwise hold, so the
  // ALU inputs stay stable for the full latency window.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_read_data1  <= '0;
      dp_read_data2  <= '0;
      dp_alu_op      <= '0;
      dp_rm          <= '0;
      dp_cvt_en      <= 1'b0;
      dp_is_unsigned <= 1'b0;
      dp_fp_rs1      <= '0;
    end else if (accept && rm_legal) begin
      dp_read_data1  <= req_rs1;
      dp_read_data2  <= req_rs2;
      dp_alu_op      <= req_op;
      dp_rm          <= rm_resolved;
      dp_cvt_en      <= (req_op == CVT_OP);
      dp_is_unsigned <= req_unsigned;
      dp_fp_rs1      <= req_rs1;
    end else if (exec_last) begin
      dp_cvt_en      <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid   <= 1'b0;
      rsp_illegal <= 1'b0;
      rsp_data    <= '0;
    end else if (accept && !rm_legal) begin
      rsp_valid   <= 1'b1;
      rsp_illegal <= 1'b1;
      rsp_data    <= '0;
    end else if (exec_last) begin
      rsp_valid   <= 1'b1;
      rsp_data    <= dp_result;
    end else if ((state == DONE) && rsp_ready) begin
      rsp_valid   <= 1'b0;
      rsp_illegal <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frm <= FRM_RST;
    end else if (frm_we) begin
      frm <= frm_wdata;
    end
  end

endmodule

// File: tb/tb_fpu_issue_sequencer.sv
// Scoreboard bench for fpu_issue_sequencer with a latency-delayed datapath stub
// and a behavioural rounding-mode / result reference model.
module tb_fpu_issue_sequencer;

  localparam int         ALU_LAT = 2;
  localparam logic [4:0] CVT     = 5'd20;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [2:0]  req_rm;
  logic        req_unsigned;
  logic        frm_we;
  logic [2:0]  frm_wdata;
  logic [2:0]  frm;
  logic [31:0] dp_read_data1;
  logic [31:0] dp_read_data2;
  logic [4:0]  dp_alu_op;
  logic [2:0]  dp_rm;
  logic        dp_cvt_en;
  logic        dp_is_unsigned;
  logic [31:0] dp_fp_rs1;
  logic [31:0] dp_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_illegal;

  int          checks = 0;
  int          errors = 0;
  logic [2:0]  model_frm;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  fpu_issue_sequencer #(.ALU_LAT(ALU_LAT), .CVT_OP(CVT), .FRM_RST(3'b000)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rm(req_rm),
    .req_unsigned(req_unsigned), .frm_we(frm_we), .frm_wdata(frm_wdata), .frm(frm),
    .dp_read_data1(dp_read_data1), .dp_read_data2(dp_read_data2),
    .dp_alu_op(dp_alu_op), .dp_rm(dp_rm), .dp_cvt_en(dp_cvt_en),
    .dp_is_unsigned(dp_is_unsigned), .dp_fp_rs1(dp_fp_rs1), .dp_result(dp_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_illegal(rsp_illegal)
  );

  // Datapath stub: result function delayed so it is valid ALU_LAT cycles
  // after the operands settle.
  logic [31:0] stub_f;
  assign stub_f = dp_cvt_en ? (32'hCAFE0000 | {31'd0, dp_is_unsigned})
                            : (dp_read_data1 ^ dp_read_data2);
  generate
    if (ALU_LAT == 1) begin : g_comb
      assign dp_result = stub_f;
    end else begin : g_pipe
      logic [31:0] pipe [ALU_LAT-1];
      always @(posedge clk) begin
        pipe[0] <= stub_f;
        for (int i = 1; i < ALU_LAT - 1; i++) pipe[i] <= pipe[i-1];
      end
      assign dp_result = pipe[ALU_LAT-2];
    end
  endgenerate

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per response handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got data %h with no pending op at %0t", rsp_data, $time);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("rsp_data", rsp_data, e[31:0]);
          check("rsp_illegal", 32'(rsp_illegal), 32'(e[32]));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic write_frm(input logic [2:0] v);
    frm_we = 1'b1;
    frm_wdata = v;
    @(posedge clk); #1;
    frm_we = 1'b0;
    model_frm = v;
    check("frm_write", 32'(frm), 32'(model_frm));
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] rm, input logic uns,
                       input logic we_acc, input logic [2:0] wd_acc,
                       input logic we_exec, input logic [2:0] wd_exec, input int hold);
    logic [2:0]  exp_rm;
    logic        legal;
    logic        exp_cvt;
    logic [31:0] exp_data;
    logic [31:0] snap_d1;
    logic [4:0]  snap_op;
    logic [2:0]  snap_rm;
    int          lat;
    exp_rm   = (rm == 3'b111) ? model_frm : rm;
    legal    = (exp_rm <= 3'b100);
    exp_cvt  = (op == CVT);
    exp_data = !legal ? 32'd0 : exp_cvt ? (32'hCAFE0000 | {31'd0, uns}) : (a ^ b);
    snap_d1  = dp_read_data1;
    snap_op  = dp_alu_op;
    snap_rm  = dp_rm;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_rm = rm; req_unsigned = uns;
    frm_we = we_acc; frm_wdata = wd_acc;
    exp_q.push_back({!legal, exp_data});
    @(posedge clk); #1;
    req_valid = 1'b0;
    frm_we = 1'b0;
    if (we_acc) model_frm = wd_acc;
    check("req_ready_busy", 32'(req_ready), 32'd0);
    if (legal) begin
      check("dp_rm", 32'(dp_rm), 32'(exp_rm));
      check("dp_alu_op", 32'(dp_alu_op), 32'(op));
      check("dp_read_data1", dp_read_data1, a);
      check("dp_read_data2", dp_read_data2, b);
      check("dp_fp_rs1", dp_fp_rs1, a);
      check("dp_is_unsigned", 32'(dp_is_unsigned), 32'(uns));
    end else begin
      check("illegal_dp_rm_kept", 32'(dp_rm), 32'(snap_rm));
      check("illegal_dp_op_kept", 32'(dp_alu_op), 32'(snap_op));
      check("illegal_dp_d1_kept", dp_read_data1, snap_d1);
    end
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      check("dp_cvt_en_exec", 32'(dp_cvt_en), 32'(exp_cvt));
      if (we_exec && lat == 1) begin
        frm_we = 1'b1;
        frm_wdata = wd_exec;
      end
      @(posedge clk); #1;
      if (frm_we) begin
        model_frm = frm_wdata;
        frm_we = 1'b0;
      end
      lat++;
    end
    check("latency", 32'(lat), legal ? 32'(ALU_LAT + 1) : 32'd1);
    check("dp_cvt_en_done", 32'(dp_cvt_en), 32'd0);
    if (legal) check("dp_rm_held", 32'(dp_rm), 32'(exp_rm));
    check("frm", 32'(frm), 32'(model_frm));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_rsp_data", rsp_data, exp_data);
      check("hold_rsp_illegal", 32'(rsp_illegal), 32'(!legal));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_valid_clear", 32'(rsp_valid), 32'd0);
    check("rsp_illegal_clear", 32'(rsp_illegal), 32'd0);
    check("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_rs1 = '0; req_rs2 = '0; req_rm = '0;
    req_unsigned = 1'b0; frm_we = 1'b0; frm_wdata = '0; rsp_ready = 1'b0;
    model_frm = 3'b000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_frm", 32'(frm), 32'd0);
    check("rst_dp_cvt_en", 32'(dp_cvt_en), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_dp_rm", 32'(dp_rm), 32'd0);

    issue(5'd0, 32'h3F800000, 32'h40000000, 3'b001, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1);
    write_frm(3'b011);
    issue(5'd2, 32'h12345678, 32'h0F0F0F0F, 3'b111, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 0);
    issue(5'd1, 32'hDEADBEEF, 32'h01010101, 3'b111, 1'b0, 1'b1, 3'b100, 1'b0, 3'd0, 0);
    issue(5'd3, 32'hAAAA5555, 32'h5555AAAA, 3'b101, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 2);
    issue(CVT, 32'h40490FDB, 32'h0, 3'b000, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 5);
    issue(5'd4, 32'h11110000, 32'h00002222, 3'b111, 1'b0, 1'b0, 3'd0, 1'b1, 3'b010, 1);
    write_frm(3'b110);
    issue(5'd5, 32'h1, 32'h2, 3'b111, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 0);

    // Reset while an op is in flight: it must vanish with no response.
    write_frm(3'b010);
    req_valid = 1'b1; req_op = CVT; req_rs1 = 32'hFFFF0000; req_rs2 = 32'h1;
    req_rm = 3'b000; req_unsigned = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("midrst_cvt_en", 32'(dp_cvt_en), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_frm = 3'b000;
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_rsp_data", rsp_data, 32'd0);
    check("midrst_rsp_illegal", 32'(rsp_illegal), 32'd0);
    check("midrst_frm", 32'(frm), 32'd0);
    check("midrst_dp_cvt_en", 32'(dp_cvt_en), 32'd0);
    check("midrst_dp_rm", 32'(dp_rm), 32'd0);
    check("midrst_dp_alu_op", 32'(dp_alu_op), 32'd0);
    check("midrst_dp_data1", dp_read_data1, 32'd0);
    check("midrst_dp_fp_rs1", dp_fp_rs1, 32'd0);
    for (int i = 0; i < ALU_LAT + 3; i++) begin
      @(posedge clk); #1;
      check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end

    for (int n = 0; n < 40; n++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 3) == 0) ? CVT : 5'($urandom_range(0, 19));
      if ($urandom_range(0, 4) == 0) write_frm(3'($urandom_range(0, 7)));
      issue(op, $urandom, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            int'($urandom_range(0, 3)));
    end

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
